// File: rtl/stat_display_if.sv
// stat_display_if: statistics inputs and scanned display outputs of stat_display
interface stat_display_if;
  logic        lock;
  logic [2:0]  sel;
  logic [31:0] total;
  logic [31:0] conditional;
  logic [31:0] unconditional;
  logic [31:0] conditional_success;
  logic [31:0] lu_times;
  logic [31:0] dbg;
  logic [31:0] shown;
  logic [7:0]  an;
  logic [7:0]  seg;
  modport master (
    output lock, sel, total, conditional, unconditional, conditional_success, lu_times, dbg,
    input  shown, an, seg
  );
  modport slave (
    input  lock, sel, total, conditional, unconditional, conditional_success, lu_times, dbg,
    output shown, an, seg
  );
endinterface

// File: rtl/stat_display.sv
// stat_display: freezable statistics bank scanned onto an 8-digit active-low 7-seg display; ports clk, rst (async high), bus (stat_display_if.slave); STAT_DISP_BLANK_EN enables leading-zero blanking
module stat_display #(
  parameter int SCAN_DIV = 50000
) (
  input logic           clk,
  input logic           rst,
  stat_display_if.slave bus
);
  localparam logic [111:0] GLYPHS = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                     7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [15:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] bank_q [5];
  logic [31:0] shown_q, shown_d;
  logic [7:0]  an_q, an_d, seg_q, seg_d;
  logic [3:0]  nib;
  logic        wrap;
`ifdef STAT_DISP_BLANK_EN
  logic [2:0]  msn;
`endif
  always_comb begin
    wrap    = div_q == 16'(SCAN_DIV - 1);
    div_d   = wrap ? 16'd0 : div_q + 16'd1;
    idx_d   = wrap ? idx_q + 3'd1 : idx_q;
    shown_d = bus.sel == 3'd0 ? bank_q[0] :
              bus.sel == 3'd1 ? bank_q[1] :
              bus.sel == 3'd2 ? bank_q[2] :
              bus.sel == 3'd3 ? bank_q[3] :
              bus.sel == 3'd4 ? bank_q[4] :
              bus.sel == 3'd5 ? bus.dbg : 32'd0;
    nib     = shown_q[{idx_q, 2'b00} +: 4];
    seg_d   = {~(idx_q == 3'd0 && bus.lock), ~GLYPHS[7'(nib) * 7'd7 +: 7]};
`ifdef STAT_DISP_BLANK_EN
    msn = 3'd0;
    for (int i = 1; i < 8; i++)
      if (shown_q[4*i +: 4] != 4'd0) msn = 3'(i);
    an_d = idx_q > msn ? 8'hFF : ~(8'h01 << idx_q);
`else
    an_d = ~(8'h01 << idx_q);
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      for (int i = 0; i < 5; i++) bank_q[i] <= '0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      if (!bus.lock) begin
        bank_q[0] <= bus.total;
        bank_q[1] <= bus.conditional;
        bank_q[2] <= bus.unconditional;
        bank_q[3] <= bus.conditional_success;
        bank_q[4] <= bus.lu_times;
      end
    end
  end
  assign bus.shown = shown_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
endmodule
